// File: rtl/brc_pipe_if.sv
// Request/result handshake bundle for brc_pipe: request side plus result side.
interface brc_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [WIDTH-1:0] in_rs1;
  logic [WIDTH-1:0] in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic             out_less;
  logic             out_equal;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_taken, out_less, out_equal, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_taken, out_less, out_equal, out_illegal, out_tag
  );
endinterface

// File: rtl/brc_pipe.sv
// Pipelined branch comparator with output register, one-entry skid buffer and flush.
// Optional saturating retire statistics are enabled by defining BRC_STATS_EN.
module brc_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input logic       clk,
  input logic       rst,
  input logic       flush,
  brc_pipe_if.slave bus
`ifdef BRC_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_taken
`endif
);

  if (WIDTH < 2 || CNT_W < 1) begin : g_param_check
    $error("brc_pipe: WIDTH must be >= 2 and CNT_W >= 1");
  end

  typedef struct packed {
    logic             taken;
    logic             less;
    logic             equal;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t       out_q, skid_q, res_new;
  logic       out_valid_q, skid_valid_q;
  logic [WIDTH:0] sum;
  logic       carry, a_msb, b_msb, less, equal;
  logic       accept, out_fire;

  // rs1 - rs2 via rs1 + ~rs2 + 1; a zero difference doubles as the equality test
  always_comb begin
    sum   = {1'b0, bus.in_rs1} + {1'b0, ~bus.in_rs2} + {{WIDTH{1'b0}}, 1'b1};
    carry = sum[WIDTH];
    a_msb = bus.in_rs1[WIDTH-1];
    b_msb = bus.in_rs2[WIDTH-1];
    equal = (sum[WIDTH-1:0] == '0);
    if (bus.in_funct3[1])
      less = ~carry;
    else
      less = (a_msb & ~b_msb) | (~(a_msb ^ b_msb) & ~carry);
  end

  always_comb begin
    res_new         = '0;
    res_new.less    = less;
    res_new.equal   = equal;
    res_new.tag     = bus.in_tag;
    unique case (bus.in_funct3)
      3'b000:         res_new.taken = equal;
      3'b001:         res_new.taken = ~equal;
      3'b100, 3'b110: res_new.taken = less;
      3'b101, 3'b111: res_new.taken = ~less;
      default:        res_new.illegal = 1'b1;
    endcase
  end

  assign bus.in_ready    = ~skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_taken   = out_q.taken;
  assign bus.out_less    = out_q.less;
  assign bus.out_equal   = out_q.equal;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_tag     = out_q.tag;

  assign accept   = bus.in_valid & ~skid_valid_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // Accept is only possible with SKID empty, so SKID->OUT and accept never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (out_fire) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_fire) begin
        out_q       <= res_new;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= res_new;
        skid_valid_q <= 1'b1;
      end
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef BRC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (out_fire) begin
      if (stat_total != '1)
        stat_total <= stat_total + 1'b1;
      if (out_q.taken && stat_taken != '1)
        stat_taken <= stat_taken + 1'b1;
    end
  end
`endif

endmodule
